// File: rtl/vid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vid_pkg
// Description : Register map, bus commands and register images shared by the
//               vid5a-style timing controller and its configuration master.
// Revision    : 1.0 - initial release
// ============================================================================
package vid_pkg;

    localparam logic [7:0] VID_CR      = 8'h00;
    localparam logic [7:0] VID_H1      = 8'h28;
    localparam logic [7:0] VID_H2      = 8'h30;
    localparam logic [7:0] VID_V1      = 8'h38;
    localparam logic [7:0] VID_V2      = 8'h40;
    localparam logic [7:0] VID_BASE    = 8'h48;
    localparam logic [7:0] VID_LINEINC = 8'h50;

    localparam logic [2:0] CMD_WR_DATA = 3'b000;
    localparam logic [2:0] CMD_WR_REQ  = 3'b100;
    localparam logic [2:0] CMD_WR_RSP  = 3'b101;

    localparam int VID_NUM_WR = 7;

    typedef struct packed {
        logic [1:0] vclk;
        logic [3:0] rsvd1;
        logic [5:0] pcnt;
        logic       en;
        logic [2:0] rsvd0;
    } vid_cr_t;

    typedef struct packed {
        logic [12:0] h_total;
        logic [12:0] h_active;
    } vid_h1_t;

    typedef struct packed {
        logic [12:0] hs_end;
        logic [12:0] hs_start;
    } vid_h2_t;

    typedef struct packed {
        logic [12:0] v_total;
        logic [12:0] v_active;
    } vid_v1_t;

    typedef struct packed {
        logic [12:0] vs_end;
        logic [12:0] vs_start;
    } vid_v2_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_RESP = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } vid_cfg_state_t;

    // CR is deliberately last: the controller locks its registers once en=1.
    function automatic logic [7:0] vid_wr_offset(input logic [2:0] idx);
        case (idx)
            3'd0:    return VID_H1;
            3'd1:    return VID_H2;
            3'd2:    return VID_V1;
            3'd3:    return VID_V2;
            3'd4:    return VID_BASE;
            3'd5:    return VID_LINEINC;
            default: return VID_CR;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/vid_cfg_master_if.sv
`default_nettype none
// ============================================================================
// Module      : vid_cfg_master_if
// Description : Initiator-side bus signals between the config master and the
//               arbiter / video controller response path.
// Revision    : 1.0 - initial release
// ============================================================================
interface vid_cfg_master_if;

    logic [1:0]  reqout;
    logic [2:0]  cmdout;
    logic [1:0]  lenout;
    logic [31:0] addrdataout;
    logic [3:0]  reqtar;
    logic        ackin;
    logic        selin;
    logic [2:0]  cmdin;

    modport master (
        output reqout, cmdout, lenout, addrdataout, reqtar,
        input  ackin, selin, cmdin
    );

    modport slave (
        input  reqout, cmdout, lenout, addrdataout, reqtar,
        output ackin, selin, cmdin
    );

endinterface
`default_nettype wire

// File: rtl/vid_cfg_master.sv
`default_nettype none
// ============================================================================
// Module      : vid_cfg_master
// Description : Programs the video timing controller with seven single-beat
//               register writes per start pulse, one outstanding at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module vid_cfg_master
    import vid_pkg::*;
#(
    parameter logic [3:0] TGT_ID       = 4'd1,
    parameter int         RESP_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [15:0]        cfg_cr,
    input  logic [25:0]        cfg_h1,
    input  logic [25:0]        cfg_h2,
    input  logic [25:0]        cfg_v1,
    input  logic [25:0]        cfg_v2,
    input  logic [31:0]        cfg_base,
    input  logic [31:0]        cfg_lineinc,
    vid_cfg_master_if.master   bus,
    output logic               busy,
    output logic               done,
    output logic               err
);

    // Last counter value tolerated in RESP; ERR then lands RESP_TIMEOUT cycles after DATA.
    localparam logic [7:0] c_tmo_last = 8'(RESP_TIMEOUT - 1);
    localparam logic [2:0] c_idx_last = 3'(VID_NUM_WR - 1);

    vid_cfg_state_t r_state;
    logic [2:0]     r_idx;
    logic [7:0]     r_cnt;
    logic [31:0]    r_wr_data [8];

    logic [7:0]     w_cnt_inc;
    logic           w_rsp;
    logic           w_accept;

    assign w_cnt_inc  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    assign w_rsp      = bus.selin && (bus.cmdin == CMD_WR_RSP);
    assign w_accept   = (r_state == ST_IDLE) && start;
    assign bus.lenout = 2'b00;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_wr_data[0] <= {6'd0, cfg_h1};
            r_wr_data[1] <= {6'd0, cfg_h2};
            r_wr_data[2] <= {6'd0, cfg_v1};
            r_wr_data[3] <= {6'd0, cfg_v2};
            r_wr_data[4] <= cfg_base;
            r_wr_data[5] <= cfg_lineinc;
            r_wr_data[6] <= {16'd0, cfg_cr};
            r_wr_data[7] <= 32'd0;
        end
    end

    // Outputs are registered against the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_idx           <= 3'd0;
            r_cnt           <= 8'd0;
            bus.reqout      <= 2'b00;
            bus.cmdout      <= CMD_WR_DATA;
            bus.addrdataout <= 32'd0;
            bus.reqtar      <= 4'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
        end else begin
            bus.reqout      <= 2'b00;
            bus.cmdout      <= CMD_WR_DATA;
            bus.addrdataout <= 32'd0;
            bus.reqtar      <= 4'd0;
            busy            <= 1'b1;
            done            <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_REQ;
                        r_idx      <= 3'd0;
                        err        <= 1'b0;
                        bus.reqout <= 2'b11;
                        bus.reqtar <= TGT_ID;
                    end else begin
                        busy <= 1'b0;
                    end
                end

                ST_REQ: begin
                    if (bus.ackin) begin
                        r_state         <= ST_ADDR;
                        bus.cmdout      <= CMD_WR_REQ;
                        bus.addrdataout <= {24'd0, vid_wr_offset(r_idx)};
                    end else begin
                        bus.reqout <= 2'b11;
                        bus.reqtar <= TGT_ID;
                    end
                end

                ST_ADDR: begin
                    r_state         <= ST_DATA;
                    bus.addrdataout <= r_wr_data[r_idx];
                end

                ST_DATA: begin
                    r_state <= ST_RESP;
                    r_cnt   <= 8'd0;
                end

                ST_RESP: begin
                    if (w_rsp) begin
                        if (r_idx == c_idx_last) begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state    <= ST_REQ;
                            r_idx      <= r_idx + 3'd1;
                            bus.reqout <= 2'b11;
                            bus.reqtar <= TGT_ID;
                        end
                    end else if (w_cnt_inc >= c_tmo_last) begin
                        r_state <= ST_ERR;
                        err     <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end

                ST_ERR: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vid_cfg_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_vid_cfg_master
// Description : Reactive arbiter/responder bench with a write-list reference
//               model for vid_cfg_master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vid_cfg_master;
    import vid_pkg::*;

    localparam int c_tmo   = 255;
    localparam int c_never = 100000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] cfg_cr;
    logic [25:0] cfg_h1, cfg_h2, cfg_v1, cfg_v2;
    logic [31:0] cfg_base, cfg_lineinc;
    logic        busy, done, err;

    int n_checks = 0;
    int n_errors = 0;
    int ack_wait [7];
    int rsp_wait [7];

    vid_cfg_master_if bus ();

    vid_cfg_master #(.TGT_ID(4'd1), .RESP_TIMEOUT(c_tmo)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_cr(cfg_cr), .cfg_h1(cfg_h1), .cfg_h2(cfg_h2),
        .cfg_v1(cfg_v1), .cfg_v2(cfg_v2),
        .cfg_base(cfg_base), .cfg_lineinc(cfg_lineinc),
        .bus(bus), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_cfg();
        cfg_cr      = 16'($urandom);
        cfg_h1      = 26'($urandom);
        cfg_h2      = 26'($urandom);
        cfg_v1      = 26'($urandom);
        cfg_v2      = 26'($urandom);
        cfg_base    = $urandom;
        cfg_lineinc = $urandom;
    endtask

    task automatic clear_waits();
        for (int i = 0; i < 7; i++) begin
            ack_wait[i] = 0;
            rsp_wait[i] = 0;
        end
    endtask

    // One programming sequence; expectations come from the write list and waits.
    task automatic run_seq(input bit stray, input bit retrig, input int rst_k);
        logic [31:0] exp_addr [7];
        logic [31:0] exp_data [7];
        int  exp_done, exp_err, stop_k, s, k, nreq, rc;
        bit  fin, in_resp, prev_req, prev_ack, prev_addr, rst_hit;

        @(negedge clk);
        start    = 1'b1;
        exp_addr = '{32'h28, 32'h30, 32'h38, 32'h40, 32'h48, 32'h50, 32'h00};
        exp_data = '{{6'd0, cfg_h1}, {6'd0, cfg_h2}, {6'd0, cfg_v1}, {6'd0, cfg_v2},
                     cfg_base, cfg_lineinc, {16'd0, cfg_cr}};
        s = 1; exp_done = -1; exp_err = -1; stop_k = 6;
        for (int i = 0; i < 7; i++) begin
            if (rsp_wait[i] >= c_never) begin
                exp_err = s + ack_wait[i] + 2 + c_tmo;
                stop_k  = i;
                break;
            end
            s += ack_wait[i] + 4 + rsp_wait[i];
        end
        if (exp_err < 0) exp_done = s;

        k = 0; nreq = 0; rc = 0;
        fin = 0; in_resp = 0; prev_req = 0; prev_ack = 0; prev_addr = 0; rst_hit = 0;

        for (int t = 1; t <= 2000 && !fin; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (retrig && (t == 6 || t == 15)) begin
                start = 1'b1;
                rand_cfg();
            end
            if (t == 1) begin
                check_eq("busy_t1", busy, 1);
                check_eq("err_clr", err, 0);
            end
            if (prev_req && prev_ack) begin
                check_eq("adr_cmd", bus.cmdout, CMD_WR_REQ);
                check_eq("adr", bus.addrdataout, exp_addr[k]);
                prev_addr = 1;
            end else if (prev_addr) begin
                check_eq("dat_cmd", bus.cmdout, 3'b000);
                check_eq("dat", bus.addrdataout, exp_data[k]);
                prev_addr = 0; in_resp = 1; rc = -1; k++;
            end else if (bus.cmdout == CMD_WR_REQ) begin
                check_eq("adr_no_grant", 1, 0);
            end
            if (prev_req && !prev_ack) check_eq("req_held", bus.reqout, 2'b11);
            if (bus.reqout == 2'b11) check_eq("reqtar", bus.reqtar, 4'd1);
            if (done) begin
                check_eq("done_t", t, exp_done);
                check_eq("n_wr", k, 7);
                check_eq("err_done", err, 0);
                fin = 1;
            end else if (err) begin
                check_eq("err_t", t, exp_err);
                check_eq("n_wr_err", k, stop_k + 1);
                fin = 1; in_resp = 0;
            end

            bus.ackin = 1'b0; bus.selin = 1'b0; bus.cmdin = 3'b000;
            prev_req = (bus.reqout == 2'b11);
            if (prev_req) begin
                bus.ackin = (nreq >= ((k < 7) ? ack_wait[k] : 0));
                nreq++;
                if (stray && !bus.ackin) begin
                    bus.selin = 1'b1;
                    bus.cmdin = CMD_WR_RSP;
                end
            end else begin
                nreq = 0;
            end
            prev_ack = bus.ackin;
            if (in_resp && !fin) begin
                if (rc == 0 && (k - 1) == rst_k) begin
                    reset = 1'b1; rst_hit = 1; fin = 1;
                end else if (rc == rsp_wait[k-1]) begin
                    bus.selin = 1'b1; bus.cmdin = CMD_WR_RSP; in_resp = 0;
                end
                rc++;
            end
            if (done && retrig) start = 1'b1;
        end

        if (!fin) check_eq("seq_timeout", 0, 1);
        @(negedge clk);
        if (rst_hit) begin
            check_eq("rst_outs", {bus.reqout, bus.cmdout, bus.lenout, bus.addrdataout,
                                  bus.reqtar, busy, done, err}, 0);
            reset = 1'b0;
        end else begin
            check_eq("idle_busy", busy, 0);
            check_eq("idle_done", done, 0);
            check_eq("err_sticky", err, exp_err >= 0);
        end
        start = 1'b0; bus.ackin = 1'b0; bus.selin = 1'b0; bus.cmdin = 3'b000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0;
        bus.ackin = 1'b0; bus.selin = 1'b0; bus.cmdin = 3'b000;
        rand_cfg();
        repeat (3) @(negedge clk);
        check_eq("reset_outs", {bus.reqout, bus.cmdout, bus.lenout, bus.addrdataout,
                                bus.reqtar, busy, done, err}, 0);
        reset = 1'b0;

        clear_waits();
        cfg_h1 = 26'h03201F4;
        run_seq(0, 0, -1);

        clear_waits(); rand_cfg();
        ack_wait[2] = 5;
        run_seq(0, 0, -1);

        clear_waits(); rand_cfg();
        ack_wait[0] = 3; ack_wait[5] = 2;
        run_seq(1, 0, -1);

        clear_waits(); rand_cfg();
        rsp_wait[4] = c_never;
        run_seq(0, 0, -1);

        clear_waits(); rand_cfg();
        rsp_wait[1] = 2;
        run_seq(0, 1, -1);

        clear_waits(); rand_cfg();
        run_seq(0, 0, 1);

        clear_waits(); rand_cfg();
        run_seq(0, 0, -1);

        for (int n = 0; n < 6; n++) begin
            rand_cfg();
            for (int i = 0; i < 7; i++) begin
                ack_wait[i] = $urandom_range(0, 3);
                rsp_wait[i] = $urandom_range(0, 3);
            end
            run_seq(n[0], n[1], -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vid_cfg_master.md
# vid_cfg_master

Bus initiator that programs the vid5a-style video timing controller over the shared bus. On a `start` pulse it issues seven single-beat register writes (H1, H2, V1, V2, BASE, LINEINC, then CR last with the enable bit) and waits for a write response to each before issuing the next. It sits between the system configuration logic and the bus arbiter, acting as the initiator end of the video controller's register-write protocol.

## Interface
- `TGT_ID`, 4'd1, target select driven on `reqtar` for the video controller
- `RESP_TIMEOUT`, 255, max cycles to wait for a write response before flagging error
- `clk` input 1 single clock, all logic on rising edge
- `reset` input 1 synchronous, active-high
- `start` input 1 one-cycle pulse; begins a programming sequence when idle
- `cfg_cr` input 16 CR image; bit 3 = en, [9:4] = pcnt, [15:14] = vclk
- `cfg_h1`, `cfg_h2`, `cfg_v1`, `cfg_v2` input 26 each; timing images, field packing per controller register map
- `cfg_base`, `cfg_lineinc` input 32 frame base address, line increment
- `ackin` input 1 arbiter grant
- `selin` input 1 response cycle is addressed to this block
- `cmdin` input 3 response command
- `reqout` output 2 bus bid (2'b11 = request)
- `cmdout` output 3 command
- `lenout` output 2 burst length (always 2'b00, single beat)
- `addrdataout` output 32 multiplexed address/data
- `reqtar` output 4 target select
- `busy` output 1 sequence in progress
- `done` output 1 one-cycle pulse, all seven writes acknowledged
- `err` output 1 sticky; set on response timeout, cleared by next accepted `start` or reset

## Operation
- Config inputs sampled into a shadow array on accepted `start`; changes afterward are ignored.
- Write order, index 0..6: 0x28 H1, 0x30 H2, 0x38 V1, 0x40 V2, 0x48 BASE, 0x50 LINEINC, 0x00 CR. CR goes last because the controller stops accepting writes once en=1.
- Data zero-extended to 32 bits; CR sent as-is, including bit 3.
- FSM states:
  - IDLE: accepted `start` -> REQ, index=0, `err` cleared.
  - REQ: `reqout`=2'b11, `reqtar`=TGT_ID; `ackin`=1 -> ADDR.
  - ADDR: one cycle; `cmdout`=3'b100, `addrdataout`=offset[index] -> DATA.
  - DATA: one cycle; `cmdout`=3'b000, `addrdataout`=data[index] -> RESP, timeout counter cleared.
  - RESP: wait for `selin`=1 and `cmdin`=3'b101.
    - Response received and index<6 -> REQ, index+1.
    - Response received and index=6 -> DONE.
    - Counter reaches RESP_TIMEOUT -> ERR.
  - DONE: one cycle, `done`=1 -> IDLE.
  - ERR: one cycle, `err` set -> IDLE; sequence aborted.
- `start` is ignored when not in IDLE. `start` arriving in the DONE/ERR cycle is also ignored.
- A response (`selin`) outside RESP is ignored.
- `busy` = state is not IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, index 0, counter 0, `err` 0.
- Outputs are registered; each reflects the current state.
- `reqout` held from REQ entry through the grant cycle; dropped in ADDR.
- Minimum sequence, with `ackin` and the response each arriving the cycle after they are awaited: per write REQ 1 + ADDR 1 + DATA 1 + RESP 1 = 4 cycles; start -> `done` = 29 cycles.
- Timeout counter is 8 bits plus saturate; it counts RESP cycles only.
- Reset mid-sequence: return to IDLE next edge; no partial bus cycle continues.

## Structure
- Shared package `vid_pkg`:
  - register offset constants: VID_CR=0x00, VID_H1=0x28, VID_H2=0x30, VID_V1=0x38, VID_V2=0x40, VID_BASE=0x48, VID_LINEINC=0x50.
  - command constants: CMD_WR_REQ=3'b100, CMD_WR_RSP=3'b101.
  - packed structs for CR/H1/H2/V1/V2; the controller uses the same package.
- No sub-module; the timeout counter stays inline.

## Test plan
- Nominal: start with cfg_h1=26'h0320_1F4, responder returns 101 one cycle after DATA -> seven writes in order 0x28..0x50, 0x00; `done` pulse at cycle 29; `err`=0.
- Arbiter delay: `ackin` withheld 5 cycles on write 3 -> `reqout` held steady, no ADDR cycle until grant, `done` at cycle 34.
- Timeout: no response to the BASE write -> `err`=1 exactly RESP_TIMEOUT cycles after DATA, the CR write is never issued, `busy`=0.
- Retrigger: `start` pulsed mid-sequence and while cfg inputs change -> ignored; data written equals values captured at the first start.
- Reset: assert `reset` during RESP of write 2 -> next cycle all outputs 0, state IDLE; a new start reruns the full sequence from 0x28.
- Stray response: `selin`=1, `cmdin`=101 during REQ -> no index advance.
